// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues word-aligned fetches, latches IR, and drives PC updates.
// Optional misaligned-fetch trap is built when FETCH_ALIGN_CHECK_EN is defined.
module inst_fetch_ctrl (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Addr,
  output logic        PCWre,
  output logic [31:0] PCData,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  input  logic        ir_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        fetch_err
);

  // state | meaning
  // IDLE  | one settle cycle after reset or redirect
  // REQ   | request outstanding at mem_addr
  // HOLD  | IR valid, waiting for decode to consume it
  // ERR   | misaligned PC trapped, waiting for redirect
`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic        w_misaligned;
  logic        w_fetch;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = (Addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign mem_addr = {Addr[31:2], 2'b00};
  assign w_fetch  = (r_state == S_REQ) && !redirect && !w_misaligned && mem_ready;
  assign IR       = r_ir;
  assign ir_valid = r_ir_valid;

  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    PCWre   = 1'b0;
    PCData  = Addr;
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        mem_req = !w_misaligned;
`ifdef FETCH_ALIGN_CHECK_EN
        if (w_misaligned)   w_next = S_ERR;
        else if (mem_ready) w_next = S_HOLD;
`else
        if (mem_ready) w_next = S_HOLD;
`endif
      end
      S_HOLD: if (ir_ack) w_next = S_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
      S_ERR: w_next = S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
    if (w_fetch) begin
      PCWre  = 1'b1;
      PCData = Addr + 32'd4;
    end
    // Redirect wins over a returning word and over decode's ack.
    if (redirect) begin
      w_next  = S_IDLE;
      mem_req = 1'b0;
      PCWre   = 1'b1;
      PCData  = redirect_addr;
    end
    if (!Reset) begin
      mem_req = 1'b0;
      PCWre   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_ir       <= 32'd0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (redirect) begin
        r_ir_valid <= 1'b0;
      end else if (w_fetch) begin
        r_ir       <= mem_rdata;
        r_ir_valid <= 1'b1;
      end else if ((r_state == S_HOLD) && ir_ack && r_ir_valid) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fetch_err;
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                                    r_fetch_err <= 1'b0;
    else if (redirect)                             r_fetch_err <= 1'b0;
    else if ((r_state == S_REQ) && w_misaligned)   r_fetch_err <= 1'b1;
  end
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: per-cycle vector table plus async-reset and throughput sequences.
module tb_inst_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Addr;
  logic        PCWre;
  logic [31:0] PCData;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] IR;
  logic        ir_valid;
  logic        ir_ack;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  inst_fetch_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Addr(Addr), .PCWre(PCWre), .PCData(PCData),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .IR(IR), .ir_valid(ir_valid), .ir_ack(ir_ack), .redirect(redirect),
    .redirect_addr(redirect_addr), .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] rdata;
    logic        ack;
    logic        redir;
    logic [31:0] raddr;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_pcd;
    logic [31:0] e_maddr;
    logic [31:0] e_ir;
    logic        e_val;
    logic        e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int cnt_valid;
  int cnt_we;
  logic [31:0] addr_m;
  logic        saw_we;

  initial begin
    //          rst addr           rdy rdata          ack redir raddr          req we pcdata         maddr          ir             val err
    vecs[0]  = '{1'b0, 32'h0,        1'b1, 32'h8C010004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0,        1'b1, 32'h8C010004, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h4,        1'b1, 32'h8C010004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h4,        32'h4,        32'h8C010004, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h4,        1'b1, 32'h8C010004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h4,        32'h4,        32'h8C010004, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 32'h4,        1'b1, 32'h8C010004, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h4,        32'h4,        32'h8C010004, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h4,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        32'h4,        32'h8C010004, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h4,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        32'h4,        32'h8C010004, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h4,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        32'h4,        32'h8C010004, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h4,        1'b1, 32'h11112222, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h4,        32'h8C010004, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h8,        1'b1, 32'h11112222, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        32'h8,        32'h11112222, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h8,        1'b1, 32'h33334444, 1'b0, 1'b1, 32'h100,      1'b0, 1'b1, 32'h100,      32'h8,        32'h11112222, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h100,      1'b1, 32'h33334444, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      32'h100,      32'h11112222, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'h100,      1'b1, 32'h55556666, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h100,      32'h11112222, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 32'h104,      1'b1, 32'h55556666, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h104,      32'h55556666, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'h77778888, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h55556666, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'h77778888, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'hFFFFFFFC, 32'h55556666, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 32'h0,        1'b1, 32'h77778888, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'h77778888, 1'b1, 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
    vecs[18] = '{1'b1, 32'h6,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h6,        32'h4,        32'h77778888, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 32'h6,        1'b1, 32'hABCD0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h6,        32'h4,        32'h77778888, 1'b0, 1'b1};
    vecs[20] = '{1'b1, 32'h6,        1'b1, 32'hABCD0000, 1'b0, 1'b1, 32'h8,        1'b0, 1'b1, 32'h8,        32'h4,        32'h77778888, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 32'h8,        1'b1, 32'h9999AAAA, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        32'h8,        32'h77778888, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 32'h8,        1'b1, 32'h9999AAAA, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h8,        32'h77778888, 1'b0, 1'b0};
`else
    vecs[18] = '{1'b1, 32'h6,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h6,        32'h4,        32'h77778888, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 32'h6,        1'b1, 32'hABCD0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hA,        32'h4,        32'h77778888, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 32'hA,        1'b1, 32'hABCD0000, 1'b0, 1'b1, 32'h8,        1'b0, 1'b1, 32'h8,        32'h8,        32'hABCD0000, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 32'h8,        1'b1, 32'h9999AAAA, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        32'h8,        32'hABCD0000, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 32'h8,        1'b1, 32'h9999AAAA, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h8,        32'hABCD0000, 1'b0, 1'b0};
`endif

    Reset = 1'b0; Addr = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    ir_ack = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < NV; i++) begin
      @(posedge CLK); #1;
      Reset = vecs[i].rst; Addr = vecs[i].addr; mem_ready = vecs[i].rdy;
      mem_rdata = vecs[i].rdata; ir_ack = vecs[i].ack; redirect = vecs[i].redir;
      redirect_addr = vecs[i].raddr;
      @(negedge CLK);
      chk($sformatf("v%0d mem_req", i),   {31'd0, mem_req},   {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d PCWre", i),     {31'd0, PCWre},     {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d PCData", i),    PCData,             vecs[i].e_pcd);
      chk($sformatf("v%0d mem_addr", i),  mem_addr,           vecs[i].e_maddr);
      chk($sformatf("v%0d IR", i),        IR,                 vecs[i].e_ir);
      chk($sformatf("v%0d ir_valid", i),  {31'd0, ir_valid},  {31'd0, vecs[i].e_val});
      chk($sformatf("v%0d fetch_err", i), {31'd0, fetch_err}, {31'd0, vecs[i].e_err});
    end

    // Async reset while holding a valid instruction.
    @(posedge CLK); #1;
    Addr = 32'hC; mem_ready = 1'b0; ir_ack = 1'b0; redirect = 1'b0;
    @(negedge CLK);
    chk("hold IR", IR, 32'h9999AAAA);
    chk("hold ir_valid", {31'd0, ir_valid}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("async ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("async IR", IR, 32'h0);
    chk("async PCWre", {31'd0, PCWre}, 32'd0);
    chk("async mem_req", {31'd0, mem_req}, 32'd0);
    redirect = 1'b1; redirect_addr = 32'h40;
    #1;
    chk("reset redirect PCWre", {31'd0, PCWre}, 32'd0);
    redirect = 1'b0;

    // Back-to-back fetches with ready and ack tied high.
    @(posedge CLK); #1;
    Reset = 1'b1; Addr = 32'h0; mem_ready = 1'b1; ir_ack = 1'b1; mem_rdata = 32'hCAFE0000;
    addr_m = 32'h0; cnt_valid = 0; cnt_we = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      saw_we = PCWre;
      if (ir_valid) cnt_valid++;
      if (PCWre) begin
        cnt_we++;
        chk($sformatf("tput c%0d PCData", c), PCData, addr_m + 32'd4);
      end
      @(posedge CLK); #1;
      if (saw_we) addr_m = addr_m + 32'd4;
      Addr = addr_m;
    end
    chk("tput fetch count", cnt_we, 32'd6);
    chk("tput valid cycles", cnt_valid, 32'd5);
    chk("tput IR", IR, 32'hCAFE0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: asynchronous active-low reset; Reset==0 clears all state immediately.
REQ-003 The block SHALL have port Addr, input, 32 bits: current PC value from the PC register.
REQ-004 The block SHALL have port PCWre, output, 1 bit: PC write enable (1 = PC loads PCData on the next rising edge).
REQ-005 The block SHALL have port PCData, output, 32 bits: next PC value.
REQ-006 The block SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-007 The block SHALL have port mem_addr, output, 32 bits: word-aligned read address, {Addr[31:2],2'b00}.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: memory returns mem_rdata this cycle.
REQ-009 The block SHALL have port mem_rdata, input, 32 bits: instruction word.
REQ-010 The block SHALL have port IR, output, 32 bits: registered instruction.
REQ-011 The block SHALL have port ir_valid, output, 1 bit: IR holds an unconsumed instruction.
REQ-012 The block SHALL have port ir_ack, input, 1 bit: decode consumed IR.
REQ-013 The block SHALL have port redirect, input, 1 bit: branch/jump taken.
REQ-014 The block SHALL have port redirect_addr, input, 32 bits: redirect target.
REQ-015 The block SHALL have port fetch_err, output, 1 bit: misaligned fetch flag (REQ-031).

Function
REQ-016 The FSM SHALL have states IDLE, REQ, HOLD, and ERR (ERR only when REQ-031 is enabled).
REQ-017 IDLE SHALL go to REQ unconditionally after one cycle, allowing PC to settle.
REQ-018 mem_req SHALL be 1 exactly while the state is REQ and redirect==0.
REQ-019 Once asserted, mem_req SHALL remain asserted with a stable mem_addr until mem_ready==1 or redirect==1.
REQ-020 If the state is REQ, mem_ready==1, and redirect==0, then on the edge: IR<=mem_rdata, ir_valid<=1, and the state goes to HOLD.
REQ-021 In the REQ+mem_ready cycle of REQ-020, PCWre SHALL be 1 and PCData SHALL be Addr+4, with modulo 2^32 wrap (0xFFFFFFFC -> 0x00000000).
REQ-022 In HOLD with ir_ack==1, on the edge: ir_valid<=0 and the state goes to REQ, so the next fetch is issued the following cycle.
REQ-023 In HOLD with ir_ack==0, the block SHALL hold IR and ir_valid, and assert no request.
REQ-024 ir_ack SHALL be ignored while ir_valid==0.
REQ-025 In any state, redirect==1 SHALL cause all of the following:
  - PCWre=1 and PCData=redirect_addr in that cycle, combinationally.
  - ir_valid<=0 and fetch_err<=0.
  - Next state IDLE.
  - Priority over mem_ready, with the returned word discarded.
  - Priority over ir_ack.
REQ-026 PCWre SHALL be 1 only in the cases of REQ-021 and REQ-025; otherwise PCWre=0 and PCData=Addr.
REQ-027 Latency from entering REQ with mem_ready tied 1 to ir_valid==1 SHALL be 1 cycle.
REQ-028 Throughput with mem_ready tied 1 and ir_ack tied 1 SHALL be one instruction per 2 cycles.

Reset
REQ-029 While Reset==0, the block SHALL hold state=IDLE, IR=0, ir_valid=0, fetch_err=0, mem_req=0, and PCWre=0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction; the memory side SHALL tolerate mem_req dropping without mem_ready.

Configuration
REQ-031 With FETCH_ALIGN_CHECK_EN defined, REQ with Addr[1:0]!=0 SHALL behave as follows:
  - mem_req=0.
  - fetch_err<=1 and the state goes to ERR.
  - ERR holds fetch_err=1 and issues no requests.
  - Only redirect (REQ-025) or reset leaves ERR.
REQ-032 Without FETCH_ALIGN_CHECK_EN, the ERR state SHALL NOT exist, fetch_err SHALL be constant 0, and Addr[1:0] SHALL be ignored.

Verification
REQ-033 Release Reset with Addr=0x0, mem_ready=1, mem_rdata=0x8C010004, ir_ack=0 -> the sequence SHALL be:
  - cycle 1: IDLE.
  - cycle 2: mem_req=1, PCWre=1, PCData=0x4.
  - cycle 3: IR=0x8C010004, ir_valid=1, mem_req=0, held while ir_ack=0.
REQ-034 mem_ready held low for 3 cycles in REQ -> mem_req=1 and mem_addr stable for 3 cycles, PCWre=0; ready on cycle 4 -> PCWre=1 in that cycle only.
REQ-035 redirect=1, redirect_addr=0x100, in the same cycle as mem_ready=1 -> PCWre=1, PCData=0x100, IR unchanged, ir_valid=0, next fetch at mem_addr=0x100.
REQ-036 Addr=0xFFFFFFFC fetch -> PCData=0x00000000.
REQ-037 With FETCH_ALIGN_CHECK_EN defined and Addr=0x6 -> mem_req stays 0 and fetch_err=1 until redirect to 0x8, after which fetch_err=0 and the fetch proceeds; without the macro -> mem_addr=0x4 and fetch_err=0.
REQ-038 Reset pulled low while in HOLD with ir_valid=1 -> ir_valid=0, IR=0, and PCWre=0 immediately, without waiting for CLK.
